// File: rtl/filter_loader.sv
// Loads a COLS x COLS kernel of 8-bit weights from a byte stream and exposes
// it both as named val outputs and through a combinational random-read port.
module filter_loader #(
  parameter int COLS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       loaded,
  output logic       busy,
  output logic [3:0] load_cnt,
  output logic [7:0] val11,
  output logic [7:0] val12,
  output logic [7:0] val13,
  output logic [7:0] val21,
  output logic [7:0] val22,
  output logic [7:0] val23,
  output logic [7:0] val31,
  output logic [7:0] val32,
  output logic [7:0] val33,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int         N    = COLS * COLS;
  localparam logic [3:0] LAST = 4'(N - 1);
  localparam logic [3:0] NUM  = 4'(N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_loaded;
  logic [7:0] r_w [0:N-1];
  logic       w_ready;
  logic       w_accept;

  // A start in the same cycle as a byte always wins, so the byte is dropped.
  assign w_ready  = (r_state == LOAD) && !start;
  assign w_accept = w_ready && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    if (w_accept && (r_cnt == LAST)) w_next = DONE;
      DONE:    if (start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_loaded <= 1'b0;
    end else if (start) begin
      r_cnt    <= 4'd0;
      r_loaded <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == LAST) r_loaded <= 1'b1;
    end
  end

  // Untouched weights keep stale values across a restart; loaded flags validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_w[i] <= 8'h00;
    end else if (w_accept) begin
      r_w[r_cnt] <= in_data;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr < NUM) rd_data = r_w[rd_addr];
  end

  assign in_ready = w_ready;
  assign busy     = (r_state == LOAD);
  assign loaded   = r_loaded;
  assign load_cnt = r_cnt;

  assign val11 = r_w[0];
  assign val12 = r_w[1];
  assign val13 = r_w[2];
  assign val21 = r_w[3];
  assign val22 = r_w[4];
  assign val23 = r_w[5];
  assign val31 = r_w[6];
  assign val32 = r_w[7];
  assign val33 = r_w[8];

endmodule

// File: tb/tb_filter_loader.sv
// Scoreboard bench for filter_loader: stimulus pushes expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_filter_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       loaded;
  logic       busy;
  logic [3:0] load_cnt;
  logic [7:0] val11, val12, val13, val21, val22, val23, val31, val32, val33;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  filter_loader #(.COLS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .loaded(loaded), .busy(busy), .load_cnt(load_cnt),
    .val11(val11), .val12(val12), .val13(val13),
    .val21(val21), .val22(val22), .val23(val23),
    .val31(val31), .val32(val32), .val33(val33),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      cnt;
    logic            loaded;
    logic            ready;
    logic            busy;
    logic [8:0][7:0] w;
    logic [7:0]      rd;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 0 idle, 1 load, 2 done.
  int              mState;
  logic [3:0]      mCnt;
  logic            mLoaded;
  logic [8:0][7:0] mW;

  logic [8:0][7:0] dutW;
  assign dutW = {val33, val32, val31, val23, val22, val21, val13, val12, val11};

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mState  = 0;
    mCnt    = 4'd0;
    mLoaded = 1'b0;
    mW      = '0;
  endtask

  task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d, input logic [3:0] a);
    exp_t e;
    logic rdy;
    @(negedge clk);
    #1;
    start = st; in_valid = v; in_data = d; rd_addr = a;
    @(posedge clk);
    rdy = (mState == 1) && !st;
    if (st) begin
      mState = 1; mCnt = 4'd0; mLoaded = 1'b0;
    end else if (rdy && v) begin
      mW[mCnt] = d;
      if (mCnt == 4'd8) begin
        mState = 2; mLoaded = 1'b1;
      end
      mCnt = mCnt + 4'd1;
    end
    e.cnt    = mCnt;
    e.loaded = mLoaded;
    e.ready  = (mState == 1) && !st;
    e.busy   = (mState == 1);
    e.w      = mW;
    e.rd     = (a < 4'd9) ? mW[a] : 8'h00;
    expQ.push_back(e);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cnt"}, {4'h0, load_cnt}, 8'h00);
    checkOutput({tag, "_loaded"}, {7'h0, loaded}, 8'h00);
    checkOutput({tag, "_ready"}, {7'h0, in_ready}, 8'h00);
    checkOutput({tag, "_busy"}, {7'h0, busy}, 8'h00);
    checkOutput({tag, "_rd"}, rd_data, 8'h00);
    for (int i = 0; i < 9; i++) checkOutput($sformatf("%s_w%0d", tag, i), dutW[i], 8'h00);
  endtask

  // Monitor: every negedge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sb_cnt", {4'h0, load_cnt}, {4'h0, e.cnt});
        checkOutput("sb_loaded", {7'h0, loaded}, {7'h0, e.loaded});
        checkOutput("sb_ready", {7'h0, in_ready}, {7'h0, e.ready});
        checkOutput("sb_busy", {7'h0, busy}, {7'h0, e.busy});
        checkOutput("sb_rd", rd_data, e.rd);
        for (int i = 0; i < 9; i++) checkOutput($sformatf("sb_w%0d", i), dutW[i], e.w[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start = 0; in_valid = 1; in_data = 8'h55; rd_addr = 4'd4;
    rst_n = 0;
    modelReset();
    #3;
    checkAllZero("rst");
    repeat (2) @(negedge clk);
    #2 rst_n = 1;

    // Basic load 01..09
    applyStimulus(1, 0, 8'h00, 0);
    for (int i = 1; i <= 9; i++) applyStimulus(0, 1, 8'(i), 0);
    checkOutput("basic_val11", val11, 8'h01);
    checkOutput("basic_val22", val22, 8'h05);
    checkOutput("basic_val33", val33, 8'h09);
    checkOutput("basic_loaded", {7'h0, loaded}, 8'h01);
    checkOutput("basic_cnt", {4'h0, load_cnt}, 8'h09);
    checkOutput("basic_ready", {7'h0, in_ready}, 8'h00);

    // Gapped load 10..18
    applyStimulus(1, 0, 8'h00, 0);
    for (int k = 0; k < 18; k++) begin
      if (k % 2 == 0) applyStimulus(0, 1, 8'(8'h10 + k / 2), 4'd4);
      else            applyStimulus(0, 0, 8'hEE, 4'd4);
    end
    checkOutput("gap_val11", val11, 8'h10);
    checkOutput("gap_val22", val22, 8'h14);
    checkOutput("gap_val33", val33, 8'h18);
    checkOutput("gap_loaded", {7'h0, loaded}, 8'h01);

    // Restart with FF presented alongside start
    applyStimulus(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'hAA + i), 0);
    checkOutput("rs_partial_loaded", {7'h0, loaded}, 8'h00);
    applyStimulus(1, 1, 8'hFF, 0);
    checkOutput("rs_cnt_clear", {4'h0, load_cnt}, 8'h00);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 8'(8'h20 + i), 0);
    checkOutput("rs_val11", val11, 8'h20);
    checkOutput("rs_val33", val33, 8'h28);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 8'h00, 4'(i));
      checkOutput($sformatf("rs_rd%0d", i), rd_data, 8'(8'h20 + i));
    end

    // Ignored input in DONE
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'h77, 4'd12);
    checkOutput("ign_cnt", {4'h0, load_cnt}, 8'h09);
    checkOutput("ign_val22", val22, 8'h24);
    checkOutput("ign_rd12", rd_data, 8'h00);

    // Reset mid-load between clock edges
    applyStimulus(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'(8'h40 + i), 4'd2);
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    checkAllZero("mid");
    modelReset();
    #2 rst_n = 1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h99, 4'd0);
    checkOutput("mid_ready_idle", {7'h0, in_ready}, 8'h00);

    // Random patterns against the model
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end

    begin
      int waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 5) begin
        @(posedge clk);
        waitCycles++;
      end
      if (expQ.size() > 0) begin
        total++;
        bad++;
        $display("[TB] FAIL drain actual=%0d expected=0", expQ.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
